// File: rtl/risc_v_pkg.sv
// Shared constants for the memory port arbiter: FSM state encodings and
// default bus widths.
package risc_v_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Width of the fairness counter; covers FAIR_LIMIT up to 15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating performance counters for the memory port arbiter.
// Built only when MEM_ARB_PERF_EN is defined.
module mem_arb_perf #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_conf,
    input  logic             inc_iwait,
    output logic [CNT_W-1:0] perf_conf,
    output logic [CNT_W-1:0] perf_iwait
);

    // Count conflict and fetch-wait cycles, holding at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conf  <= '0;
            perf_iwait <= '0;
        end else begin
            if (inc_conf && (perf_conf != '1))
                perf_conf <= perf_conf + 1'b1;
            if (inc_iwait && (perf_iwait != '1))
                perf_iwait <= perf_iwait + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and the
// MEM-stage load/store port (D). D normally wins; a starvation counter lets
// I through after FAIR_LIMIT consecutive D grants while I was waiting.
// Optional feature: define MEM_ARB_PERF_EN to build the perf counters.
module mem_port_arbiter
    import risc_v_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FAIR_LIMIT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    perf_conf,
    output logic [CNT_W-1:0]    perf_iwait
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(FAIR_LIMIT);

    logic [1:0]          state;
    logic [STARVE_W-1:0] starve;
    logic                grant_d;
    logic                grant_i;

    // Winner selection in IDLE: D unless I has been starved long enough.
    assign grant_d = d_req & (~i_req | (starve < LIMIT));
    assign grant_i = ~grant_d & i_req;

    // Acks only in the matching BUSY state, so they are mutually exclusive
    // and a mem_ready seen in IDLE has no effect.
    assign mem_req   = (state != ARB_IDLE);
    assign i_ack     = (state == ARB_BUSY_I) & mem_ready;
    assign d_ack     = (state == ARB_BUSY_D) & mem_ready;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

    // Access sequencer: latch the winner's request at grant, hold it until
    // the memory reports completion, then return to IDLE for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            starve    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state     <= ARB_BUSY_D;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : '0;
                        if (i_req && (starve < LIMIT))
                            starve <= starve + 1'b1;
                    end else if (grant_i) begin
                        state     <= ARB_BUSY_I;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        starve    <= '0;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (mem_ready)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .reset      (reset),
        .inc_conf   (i_req & d_req & ~i_ack & ~d_ack),
        .inc_iwait  (stall_if),
        .perf_conf  (perf_conf),
        .perf_iwait (perf_iwait)
    );
`else
    assign perf_conf  = '0;
    assign perf_iwait = '0;
`endif

endmodule
